// File: rtl/pipe_multiplier.sv
// Pipelined full-width multiplier with per-operation signedness, opaque tag and
// valid/ready handshake. Stall freezes every stage; flush drops everything in flight.
module pipe_multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2,
    parameter int TAG_LEN        = 8
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    flush,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    in_signed,
    input  logic [DATA_LEN-1:0]                     in_a,
    input  logic [DATA_LEN-1:0]                     in_b,
    input  logic [TAG_LEN-1:0]                      in_tag,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [2*DATA_LEN-1:0]                   out_result,
    output logic                                    out_ovf,
    output logic [TAG_LEN-1:0]                      out_tag,
    output logic [$clog2(PIPELINE_STAGE+1)-1:0]     occupancy
);

    localparam int OCC_W = $clog2(PIPELINE_STAGE + 1);
    localparam int PW    = 2 * DATA_LEN;

    // Returns {ovf, product}; both operands are widened to PW bits so one
    // modulo-2^PW multiply covers signed and unsigned operation.
    function automatic logic [PW:0] mul_full(input logic [DATA_LEN-1:0] a,
                                             input logic [DATA_LEN-1:0] b,
                                             input logic                sgn);
        logic [PW-1:0]     ea;
        logic [PW-1:0]     eb;
        logic [PW-1:0]     p;
        logic [DATA_LEN:0] top;
        logic              ovf;
        ea  = {{DATA_LEN{sgn & a[DATA_LEN-1]}}, a};
        eb  = {{DATA_LEN{sgn & b[DATA_LEN-1]}}, b};
        p   = ea * eb;
        top = p[PW-1:DATA_LEN-1];
        if (sgn) begin
            ovf = !((&top) || !(|top));
        end else begin
            ovf = |p[PW-1:DATA_LEN];
        end
        return {ovf, p};
    endfunction

    logic [PIPELINE_STAGE-1:0] vld_q;
    logic [TAG_LEN-1:0]        tag_q [PIPELINE_STAGE];
    logic [OCC_W-1:0]          occ_q;
    logic                      stall;
    logic                      accept;
    logic                      out_fire;

    assign out_valid = vld_q[PIPELINE_STAGE-1];
    assign out_tag   = tag_q[PIPELINE_STAGE-1];
    assign occupancy = occ_q;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < PIPELINE_STAGE; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (!stall) begin
                vld_q[0] <= accept;
                for (int i = 1; i < PIPELINE_STAGE; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
            if (!stall) begin
                tag_q[0] <= in_tag;
                for (int i = 1; i < PIPELINE_STAGE; i++) begin
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (accept && !out_fire) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (out_fire && !accept) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    generate
        if (PIPELINE_STAGE == 1) begin : g_single
            logic [PW-1:0] res_q;
            logic          ovf_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    res_q <= '0;
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    {ovf_q, res_q} <= mul_full(in_a, in_b, in_signed);
                end
            end

            assign out_result = res_q;
            assign out_ovf    = ovf_q;
        end else begin : g_multi
            // Stage 0 only registers the operands; the multiply sits between
            // stage 0 and stage 1, later stages are plain delay.
            logic [DATA_LEN-1:0] a_q;
            logic [DATA_LEN-1:0] b_q;
            logic                sgn_q;
            logic [PW-1:0]       res_q [PIPELINE_STAGE-1:1];
            logic                ovf_q [PIPELINE_STAGE-1:1];
            logic [PW:0]         prod;

            assign prod = mul_full(a_q, b_q, sgn_q);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sgn_q <= 1'b0;
                    for (int i = 1; i < PIPELINE_STAGE; i++) begin
                        res_q[i] <= '0;
                        ovf_q[i] <= 1'b0;
                    end
                end else if (!stall) begin
                    a_q      <= in_a;
                    b_q      <= in_b;
                    sgn_q    <= in_signed;
                    res_q[1] <= prod[PW-1:0];
                    ovf_q[1] <= prod[PW];
                    for (int i = 2; i < PIPELINE_STAGE; i++) begin
                        res_q[i] <= res_q[i-1];
                        ovf_q[i] <= ovf_q[i-1];
                    end
                end
            end

            assign out_result = res_q[PIPELINE_STAGE-1];
            assign out_ovf    = ovf_q[PIPELINE_STAGE-1];
        end
    endgenerate

endmodule

// File: tb/tb_pipe_multiplier.sv
// Bench for pipe_multiplier: arithmetic/queue reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_pipe_multiplier;

    localparam int DL = 32;
    localparam int PS = 2;
    localparam int TL = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_signed = 1'b0;
    logic [DL-1:0] in_a = '0;
    logic [DL-1:0] in_b = '0;
    logic [TL-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*DL-1:0] out_result;
    logic          out_ovf;
    logic [TL-1:0] out_tag;
    logic [$clog2(PS+1)-1:0] occupancy;

    int checks = 0;
    int errors = 0;
    int fires = 0;
    int occ_peak = 0;
    logic acc_last = 1'b0;

    pipe_multiplier #(.DATA_LEN(DL), .PIPELINE_STAGE(PS), .TAG_LEN(TL)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_tag(out_tag),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: true product, overflow judged by numeric range.
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;
    function automatic logic [64:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        longint      sp;
        logic [63:0] up;
        logic        ovf;
        if (s) begin
            sp  = longint'($signed(a)) * longint'($signed(b));
            ovf = (sp > SMAX) || (sp < SMIN);
            return {ovf, 64'(sp)};
        end
        up  = {32'd0, a} * {32'd0, b};
        ovf = up > 64'h0000_0000_FFFF_FFFF;
        return {ovf, up};
    endfunction

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        logic [7:0]  tag;
        int          age;
    } op_t;

    op_t mq[$];
    logic m_vld, m_stall, m_acc;
    logic [64:0] m_prod;
    op_t  m_new;

    // Each in-flight op ages by one per unstalled cycle and sits at the output once age == PS.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
        end else begin
            m_vld   = (mq.size() > 0) && (mq[0].age == PS);
            m_stall = m_vld && !out_ready;
            m_acc   = in_valid && !m_stall && !flush;
            if (m_vld && out_ready) fires++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_vld && out_ready) void'(mq.pop_front());
                if (!m_stall) begin
                    foreach (mq[i]) mq[i].age++;
                end
                if (m_acc) begin
                    m_prod    = model_mul(in_a, in_b, in_signed);
                    m_new.res = m_prod[63:0];
                    m_new.ovf = m_prod[64];
                    m_new.tag = in_tag;
                    m_new.age = 1;
                    mq.push_back(m_new);
                end
            end
        end
    end

    logic c_vld;
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_occupancy", 64'(occupancy), 64'd0);
            chk("rst_out_result", out_result, 64'd0);
            chk("rst_out_ovf", 64'(out_ovf), 64'd0);
            chk("rst_out_tag", 64'(out_tag), 64'd0);
        end else begin
            c_vld = (mq.size() > 0) && (mq[0].age == PS);
            chk("out_valid", 64'(out_valid), 64'(c_vld));
            chk("occupancy", 64'(occupancy), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(!(c_vld && !out_ready) && !flush));
            if (c_vld) begin
                chk("out_result", out_result, mq[0].res);
                chk("out_ovf", 64'(out_ovf), 64'(mq[0].ovf));
                chk("out_tag", 64'(out_tag), 64'(mq[0].tag));
            end
            if (int'(occupancy) > occ_peak) occ_peak = int'(occupancy);
        end
    end

    task automatic tick();
        @(negedge clk);
        acc_last = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [7:0] t);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = t;
    endtask

    task automatic single(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [7:0] t, input logic [63:0] er, input logic eo,
                          input string nm);
        int n;
        drive(a, b, s, t);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid stayed 0 for %0d cycles, required 1", nm, n);
        end else begin
            chk({nm, "_res"}, out_result, er);
            chk({nm, "_ovf"}, 64'(out_ovf), 64'(eo));
            chk({nm, "_tag"}, 64'(out_tag), 64'(t));
        end
        tick();
    endtask

    task automatic wait_accept(input string nm);
        int n;
        n = 0;
        tick();
        while (!acc_last && n < 30) begin
            tick();
            n++;
        end
        if (!acc_last) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: not accepted within %0d cycles", nm, n);
        end
    endtask

    int f0;
    int nacc;
    int c;
    logic [7:0] rdy_pat;

    initial begin
        #1 reset_n = 1'b0;
        #2;
        chk("por_out_valid", 64'(out_valid), 64'd0);
        chk("por_out_result", out_result, 64'd0);
        repeat (3) tick();
        #2 reset_n = 1'b1;
        #1 chk("ready_after_reset", 64'(in_ready), 64'd1);

        // Latency: accepted in cycle 0, presented in cycle 2.
        drive(32'd7, 32'd6, 1'b0, 8'h11);
        tick();
        in_valid = 1'b0;
        chk("lat_c1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("lat_c2_valid", 64'(out_valid), 64'd1);
        chk("lat_c2_res", out_result, 64'd42);
        chk("lat_c2_ovf", 64'(out_ovf), 64'd0);
        chk("lat_c2_tag", 64'(out_tag), 64'h11);
        tick();

        single(32'hFFFF_FFFD, 32'd5, 1'b1, 8'h21, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, "s_m3x5");
        single(32'hFFFF_FFFD, 32'd5, 1'b0, 8'h22, 64'h0000_0004_FFFF_FFF1, 1'b1, "u_m3x5");
        single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 8'h23, 64'hFFFF_FFFE_0000_0001, 1'b1, "u_max");
        single(32'h8000_0000, 32'h8000_0000, 1'b1, 8'h24, 64'h4000_0000_0000_0000, 1'b1, "s_minmin");
        single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 8'h25, 64'h0000_0000_0000_0001, 1'b0, "s_m1m1");
        single(32'h8000_0000, 32'd1, 1'b1, 8'h26, 64'hFFFF_FFFF_8000_0000, 1'b0, "s_minx1");
        single(32'h4000_0000, 32'd2, 1'b1, 8'h27, 64'h0000_0000_8000_0000, 1'b1, "s_edge_ovf");
        single(32'h0000_FFFF, 32'h0001_0001, 1'b0, 8'h28, 64'h0000_0000_FFFF_FFFF, 1'b0, "u_edge_fit");

        // Back-to-back with mixed signedness.
        occ_peak = 0;
        f0 = fires;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(32'd1000 + 32'(i) * 32'h1111_1111, 32'hFFFF_FFF0 + 32'(i), i[0], 8'(8'h40 + i));
            tick();
            if (acc_last) nacc++;
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("b2b_accepted", 64'(nacc), 64'd8);
        chk("b2b_results", 64'(fires - f0), 64'd8);
        chk("b2b_peak_occ", 64'(occ_peak), 64'd2);

        // Backpressure with a full pipeline.
        f0 = fires;
        out_ready = 1'b0;
        drive(32'd100, 32'd3, 1'b0, 8'h61);
        tick();
        drive(32'd200, 32'd3, 1'b0, 8'h62);
        tick();
        drive(32'd300, 32'd3, 1'b0, 8'h63);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_occ", 64'(occupancy), 64'd2);
            chk("bp_res_held", out_result, 64'd300);
            chk("bp_tag_held", 64'(out_tag), 64'h61);
            tick();
        end
        out_ready = 1'b1;
        wait_accept("bp_op3");
        drive(32'd400, 32'd3, 1'b0, 8'h64);
        wait_accept("bp_op4");
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_no_loss_dup", 64'(fires - f0), 64'd4);

        // Irregular consumer.
        rdy_pat = 8'b1011_0011;
        c = 0;
        f0 = fires;
        for (int i = 0; i < 10; i++) begin
            drive(32'h0123_4567 * 32'(i + 1), 32'h8000_0001 - 32'(i), i[1], 8'(8'h80 + i));
            out_ready = rdy_pat[c % 8];
            c++;
            tick();
            while (!acc_last && c < 400) begin
                out_ready = rdy_pat[c % 8];
                c++;
                tick();
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("irr_all_out", 64'(fires - f0), 64'd10);

        // Flush with two ops in flight and a competing operand.
        drive(32'd11, 32'd13, 1'b0, 8'hA1);
        tick();
        drive(32'd17, 32'd19, 1'b0, 8'hA2);
        tick();
        chk("fl_occ_before", 64'(occupancy), 64'd2);
        flush = 1'b1;
        drive(32'd23, 32'd29, 1'b0, 8'hA3);
        #1 chk("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ_after", 64'(occupancy), 64'd0);
        chk("fl_valid_after", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("fl_no_result", 64'(out_valid), 64'd0);
            tick();
        end

        // Reset mid-stream.
        drive(32'd5, 32'd5, 1'b0, 8'hB1);
        tick();
        drive(32'd6, 32'd6, 1'b0, 8'hB2);
        tick();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_res", out_result, 64'd0);
        tick();
        tick();
        #2 reset_n = 1'b1;
        #1 chk("mid_rst_ready", 64'(in_ready), 64'd1);
        single(32'h8000_0000, 32'd2, 1'b0, 8'hC1, 64'h0000_0001_0000_0000, 1'b1, "post_rst");
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, %0d checks so far", checks);
        $fatal(1, "timeout");
    end

endmodule
